// File: rtl/regfile_pkg.sv
// Shared register-file widths and the writeback request bundle.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational rotating-priority arbiter: first request at or after ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  int j;

  // Scan from farthest to nearest so the nearest match is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with debug priority and a
// pending-write scoreboard for RAW/WAW stall detection.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*5-1:0]    req_rd,
  input  logic [N_REQ*32-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  dbg_valid,
  input  logic [4:0]            dbg_rd,
  input  logic [31:0]           dbg_data,
  output logic                  dbg_ready,
  input  logic                  sb_set,
  input  logic [4:0]            sb_set_rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  waw_stall,
  output logic                  w_en,
  output logic [4:0]            rd,
  output logic [31:0]           rdv,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]       rr_ptr;
  logic [N_REQ-1:0]    grant;
  logic [PW-1:0]       gidx;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  wb_req_t             reqs [N_REQ];
  wb_req_t             sel;
  logic                xfer;
  logic                req_xfer;
  int                  nreq;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      reqs[i].rd   = req_rd[5*i +: 5];
      reqs[i].data = req_data[32*i +: 32];
    end
  end

  assign dbg_ready = dbg_valid;
  assign req_ready = dbg_valid ? '0 : grant;
  assign req_xfer  = !dbg_valid && (|req_valid);
  assign xfer      = dbg_valid || req_xfer;

  always_comb begin
    sel = reqs[gidx];
    if (dbg_valid) begin
      sel.rd   = dbg_rd;
      sel.data = dbg_data;
    end
  end

  always_comb begin
    nreq = int'(dbg_valid);
    for (int i = 0; i < N_REQ; i++)
      nreq = nreq + int'(req_valid[i]);
  end

  // A new producer marked on the same edge as a retiring write must win.
  always_comb begin
    pending_nxt = pending;
    if (w_en)
      pending_nxt[rd] = 1'b0;
    if (sb_set && sb_set_rd != '0)
      pending_nxt[sb_set_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign rs1_busy  = (rs1 != '0) && pending[rs1];
  assign rs2_busy  = (rs2 != '0) && pending[rs2];
  assign waw_stall = sb_set && (sb_set_rd != '0)
                   && pending[sb_set_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_en         <= 1'b0;
      rd           <= '0;
      rdv          <= '0;
      pending      <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      w_en    <= xfer && (sel.rd != '0);
      pending <= pending_nxt;
      if (xfer) begin
        rd  <= sel.rd;
        rdv <= sel.data;
      end
      if (req_xfer)
        rr_ptr <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
      if (nreq >= 2 && conflict_cnt != {CNT_W{1'b1}})
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
